mov8_bus_sequencer: RTL and testbench

//  Sequences one 8-bit register-to-register move on the shared data bus.

---
 rtl/relay_pkg.sv | 10 +
 rtl/mov8_bus_sequencer_phase_timer.sv | 18 +
 rtl/mov8_bus_sequencer.sv | 106 ++++++++++
 tb/tb_mov8_bus_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// relay_pkg: register ids, bus widths and sequencer states shared by the move sequencer.
package relay_pkg;
  typedef enum logic [3:0] {A = 4'd0, B, C, D, M1, M2, X, Y, J1 = 4'd8, J2 = 4'd9} reg_id_t;
  localparam int NUM_SRC = 8;
  localparam int NUM_DST = 10;
  typedef enum logic [2:0] {IDLE, SELECT, LOAD, RELEASE, DONE} seq_state_t;
  function automatic logic legal_move(input logic [3:0] s, input logic [3:0] d);
    return s < 4'(NUM_SRC) && d < 4'(NUM_DST) && s != d;
  endfunction
endpackage

// File: rtl/mov8_bus_sequencer_phase_timer.sv
// phase_timer: loadable down-counter that stops at zero, shared by the timed phases.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else if (load_i) cnt_q <= value_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/mov8_bus_sequencer.sv
// mov8_bus_sequencer: drives a source select, then a destination load strobe, with settle/load/hold timing.
module mov8_bus_sequencer
  import relay_pkg::*;
#(
  parameter int SEL_CYCLES  = 2,
  parameter int LD_CYCLES   = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_src,
  input  logic [3:0]         req_dst,
  output logic [NUM_SRC-1:0] sel,
  output logic [NUM_DST-1:0] ld,
  output logic               busy,
  output logic               done,
  output logic               err
);
  seq_state_t state_q, state_d;
  logic [3:0] src_q, src_d, dst_q, dst_d;
  logic [NUM_SRC-1:0] sel_q, sel_d;
  logic [NUM_DST-1:0] ld_q, ld_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, ready_q, ready_d;
  logic fire, zero, tload;
  logic [CNT_W-1:0] tval;
  assign fire  = req_valid && ready_q;
  assign src_d = fire ? req_src : src_q;
  assign dst_d = fire ? req_dst : dst_q;
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load_i (tload),
    .value_i(tval),
    .zero_o (zero)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end
  always_comb begin
    state_d = state_q;
    tload   = 1'b0;
    tval    = '0;
    case (state_q)
      IDLE: if (fire && legal_move(req_src, req_dst)) begin
        state_d = SELECT;
        tload   = 1'b1;
        tval    = CNT_W'(SEL_CYCLES - 1);
      end
      SELECT: if (zero) begin
        state_d = LOAD;
        tload   = 1'b1;
        tval    = CNT_W'(LD_CYCLES - 1);
      end
      LOAD: if (zero) begin
        state_d = RELEASE;
        tload   = 1'b1;
        tval    = CNT_W'(HOLD_CYCLES - 1);
      end
      RELEASE: state_d = zero ? DONE : RELEASE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    sel_d   = (state_d inside {SELECT, LOAD, RELEASE}) ? NUM_SRC'(1) << src_d : '0;
    ld_d    = (state_d == LOAD) ? NUM_DST'(1) << dst_d : '0;
    busy_d  = state_d != IDLE;
    ready_d = state_d == IDLE;
    done_d  = state_d == DONE;
    err_d   = fire && !legal_move(req_src, req_dst);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q   <= '0;
      ld_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      sel_q   <= sel_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end
  assign sel       = sel_q;
  assign ld        = ld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign req_ready = ready_q;
endmodule

// File: tb/tb_mov8_bus_sequencer.sv
// tb_mov8_bus_sequencer: randomized moves checked against a cycle-window model, default and 1/1/1 timing.
module tb_mov8_bus_sequencer;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, which = 1'b0;
  logic [3:0] src = '0, dst = '0;
  logic [7:0] sel, sel0, sel1;
  logic [9:0] ld, ld0, ld1;
  logic busy, done, err, ready, busy0, done0, err0, ready0, busy1, done1, err1, ready1;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mov8_bus_sequencer dut0 (
    .clock(clk), .reset(rst), .req_valid(valid && !which), .req_ready(ready0),
    .req_src(src), .req_dst(dst), .sel(sel0), .ld(ld0), .busy(busy0), .done(done0), .err(err0)
  );
  mov8_bus_sequencer #(.SEL_CYCLES(1), .LD_CYCLES(1), .HOLD_CYCLES(1)) dut1 (
    .clock(clk), .reset(rst), .req_valid(valid && which), .req_ready(ready1),
    .req_src(src), .req_dst(dst), .sel(sel1), .ld(ld1), .busy(busy1), .done(done1), .err(err1)
  );
  assign sel   = which ? sel1 : sel0;
  assign ld    = which ? ld1 : ld0;
  assign busy  = which ? busy1 : busy0;
  assign done  = which ? done1 : done0;
  assign err   = which ? err1 : err0;
  assign ready = which ? ready1 : ready0;

  // Expected {sel, ld, busy, done, err, ready} k cycles after an accepted legal move.
  function automatic logic [21:0] expv(int k, int sc, int lc, int hc, logic [3:0] s, logic [3:0] d);
    int n = sc + lc + hc + 1;
    logic [7:0] es = (k >= 1 && k < n) ? 8'd1 << s : 8'd0;
    logic [9:0] el = (k > sc && k <= sc + lc) ? 10'd1 << d : 10'd0;
    return {es, el, (k >= 1 && k <= n), (k == n), 1'b0, !(k >= 1 && k <= n)};
  endfunction

  task automatic present(input logic [3:0] s, input logic [3:0] d);
    valid = 1'b1;
    src = s;
    dst = d;
  endtask

  task automatic rand_legal(output logic [3:0] s, output logic [3:0] d);
    s = 4'($urandom_range(0, 7));
    d = 4'($urandom_range(0, 9));
    while (d == s) d = 4'($urandom_range(0, 9));
  endtask

  task automatic check_move(input logic [3:0] s, input logic [3:0] d, input bit hold);
    int sc = which ? 1 : 2;
    int lc = which ? 1 : 2;
    int n = sc + lc + 2;
    int run = 0;
    logic [21:0] e, o;
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_ready: ready=%b want 1", ready);
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      e = expv(k, sc, lc, 1, s, d);
      o = {sel, ld, busy, done, err, ready};
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL move src=%0d dst=%0d cycle %0d: got sel=%h ld=%h b/d/e/r=%b want sel=%h ld=%h b/d/e/r=%b",
                 s, d, k, o[21:14], o[13:4], o[3:0], e[21:14], e[13:4], e[3:0]);
      end
      run = (sel != 8'd0) ? run + 1 : 0;
      tests++;
      if (!$onehot0(sel) || !$onehot0(ld) || (ld != 10'd0 && run <= sc)) begin
        fails++;
        $display("FAIL invariant cycle %0d: sel=%h ld=%h sel_run=%0d need >%0d", k, sel, ld, run, sc);
      end
      valid = hold;
      if (hold) begin
        src = 4'($urandom);
        dst = 4'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({sel, ld, busy, done, err, ready} !== 22'b1) begin
      fails++;
      $display("FAIL reset: got sel=%h ld=%h b/d/e/r=%b%b%b%b want 0,0,0001", sel, ld, busy, done, err, ready);
    end
  endtask

  task automatic test_basic();
    present(4'd0, 4'd1);
    check_move(4'd0, 4'd1, 1'b0);
    @(negedge clk);
    present(relay_pkg::Y, relay_pkg::J1);
    check_move(relay_pkg::Y, relay_pkg::J1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random_moves();
    logic [3:0] s, d;
    for (int i = 0; i < 8; i++) begin
      rand_legal(s, d);
      present(s, d);
      check_move(s, d, 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      else begin
        @(negedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ss[6] = '{4'd9, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    logic [3:0] dd[6] = '{4'd0, 4'd2, 4'd12, 4'd0, 4'd0, 4'd0};
    for (int i = 3; i < 6; i++) begin
      ss[i] = 4'($urandom_range(8, 15));
      dd[i] = 4'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      present(ss[i], dd[i]);
      @(negedge clk);
      valid = 1'b0;
      tests++;
      if ({sel, ld, busy, done, err, ready} !== 22'b0011) begin
        fails++;
        $display("FAIL illegal src=%0d dst=%0d: sel=%h ld=%h b/d/e/r=%b%b%b%b want 0,0,0011",
                 ss[i], dd[i], sel, ld, busy, done, err, ready);
      end
      @(negedge clk);
      tests++;
      if ({sel, ld, busy, done, err, ready} !== 22'b0001) begin
        fails++;
        $display("FAIL illegal_after src=%0d dst=%0d: sel=%h ld=%h b/d/e/r=%b%b%b%b want 0,0,0001",
                 ss[i], dd[i], sel, ld, busy, done, err, ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s, d, s2, d2;
    for (int i = 0; i < 3; i++) begin
      rand_legal(s, d);
      rand_legal(s2, d2);
      present(s, d);
      check_move(s, d, 1'b1);
      @(negedge clk);
      present(s2, d2);
      check_move(s2, d2, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [3:0] s, d;
    bit seen = 1'b0;
    rand_legal(s, d);
    present(s, d);
    repeat (3) begin
      @(negedge clk);
      valid = 1'b0;
    end
    tests++;
    if (ld !== 10'd1 << d) begin
      fails++;
      $display("FAIL mid_load_ld: ld=%h want %h", ld, 10'd1 << d);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({sel, ld, busy, done, err} !== 21'b0) begin
      fails++;
      $display("FAIL reset_abort: sel=%h ld=%h busy=%b done=%b err=%b want all 0", sel, ld, busy, done, err);
    end
    repeat (8) begin
      @(negedge clk);
      seen |= done | err;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL aborted_pulse: done/err seen=%b want 0", seen);
    end
    rand_legal(s, d);
    present(s, d);
    check_move(s, d, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_fast_timing();
    logic [3:0] s, d;
    which = 1'b1;
    do_reset();
    present(4'd0, 4'd1);
    check_move(4'd0, 4'd1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rand_legal(s, d);
      present(s, d);
      check_move(s, d, i[0]);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_moves();
    test_illegal();
    test_back_to_back();
    test_reset_mid_load();
    test_fast_timing();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
